// File: rtl/toysram_wb_pkg.sv
// Shared definitions for the Wishbone initiator.
//   WB_AW / WB_DW / WB_SELW : address, data and byte-select widths
//   wb_state_e              : initiator FSM states
package toysram_wb_pkg;

  localparam int WB_AW   = 32;
  localparam int WB_DW   = 32;
  localparam int WB_SELW = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_initiator_if.sv
// Bundle of the initiator's command, response and Wishbone master signals.
//   master : the view of wb_initiator (drives cmd_ready, rsp_*, wbm_*_o)
//   slave  : the view of the environment (drives cmd_*, rsp_ready, wbm_ack_i/dat_i)
interface wb_initiator_if;
  import toysram_wb_pkg::*;

  // command channel
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_we;
  logic [WB_SELW-1:0] cmd_sel;
  logic [WB_AW-1:0]   cmd_adr;
  logic [WB_DW-1:0]   cmd_dat;

  // response channel
  logic               rsp_valid;
  logic               rsp_ready;
  logic [WB_DW-1:0]   rsp_dat;
  logic               rsp_err;

  // Wishbone classic bus
  logic               wbm_cyc_o;
  logic               wbm_stb_o;
  logic               wbm_we_o;
  logic [WB_SELW-1:0] wbm_sel_o;
  logic [WB_AW-1:0]   wbm_adr_o;
  logic [WB_DW-1:0]   wbm_dat_o;
  logic               wbm_ack_i;
  logic [WB_DW-1:0]   wbm_dat_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_sel, cmd_adr, cmd_dat,
    output cmd_ready,
    output rsp_valid, rsp_dat, rsp_err,
    input  rsp_ready,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_ack_i, wbm_dat_i
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_sel, cmd_adr, cmd_dat,
    input  cmd_ready,
    input  rsp_valid, rsp_dat, rsp_err,
    output rsp_ready,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_ack_i, wbm_dat_i
  );

endinterface

// File: rtl/wb_init_timer.sv
// Ack-wait counter for the Wishbone initiator.
//   wb_clk_i, wb_rst_i : clock, asynchronous active-low reset
//   clear              : zero the counter (transfer start)
//   enable             : count this cycle (waiting, no ack)
//   expired            : this counting cycle brings the count to TIMEOUT
module wb_init_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Flag the edge on which the count would reach TIMEOUT, so the bus
  // phase lasts exactly TIMEOUT cycles when the slave never answers.
  assign expired = enable && (cnt_q == LAST);

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone classic initiator: takes one command over a
// valid/ready channel, runs it on the bus with an ack timeout, and returns
// the result over a valid/ready response channel.
//   wb_clk_i  : clock
//   wb_rst_i  : asynchronous active-low reset
//   bus       : command/response/Wishbone signals (master view)
//   busy      : high whenever a transfer is in flight (state not IDLE)
//   xfer_cnt  : acked transfers, wraps
//   err_cnt   : timed-out transfers, saturates at 0xFF
module wb_initiator
  import toysram_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  wb_initiator_if.master      bus,
  output logic                busy,
  output logic [15:0]         xfer_cnt,
  output logic [7:0]          err_cnt
);

  wb_state_e          state_q, state_d;
  logic               rdy_q;
  logic               cyc_q, cyc_d;
  logic               we_q, we_d;
  logic [WB_SELW-1:0] sel_q, sel_d;
  logic [WB_AW-1:0]   adr_q, adr_d;
  logic [WB_DW-1:0]   dat_q, dat_d;
  logic [WB_DW-1:0]   rsp_dat_q, rsp_dat_d;
  logic               rsp_err_q, rsp_err_d;
  logic [15:0]        xfer_q, xfer_d;
  logic [7:0]         err_q, err_d;

  logic accept;
  logic timer_en;
  logic expired;

  // rdy_q keeps cmd_ready low through reset and for the release edge itself.
  assign accept   = (state_q == ST_IDLE) && rdy_q && bus.cmd_valid;
  assign timer_en = (state_q == ST_REQ) && !bus.wbm_ack_i;

  wb_init_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .clear    (accept),
    .enable   (timer_en),
    .expired  (expired)
  );

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    sel_d     = sel_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    rsp_dat_d = rsp_dat_q;
    rsp_err_d = rsp_err_q;
    xfer_d    = xfer_q;
    err_d     = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          we_d    = bus.cmd_we;
          sel_d   = bus.cmd_sel;
          adr_d   = bus.cmd_adr;
          dat_d   = bus.cmd_dat;
          cyc_d   = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // Ack wins over a simultaneous timeout.
        if (bus.wbm_ack_i) begin
          cyc_d     = 1'b0;
          rsp_dat_d = we_q ? '0 : bus.wbm_dat_i;
          rsp_err_d = 1'b0;
          xfer_d    = xfer_q + 16'd1;
          state_d   = ST_RSP;
        end else if (expired) begin
          cyc_d     = 1'b0;
          rsp_dat_d = '0;
          rsp_err_d = 1'b1;
          err_d     = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
          state_d   = ST_RSP;
        end
      end
      ST_RSP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cyc_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q   <= ST_IDLE;
      rdy_q     <= 1'b0;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
      xfer_q    <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      rdy_q     <= 1'b1;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
      xfer_q    <= xfer_d;
      err_q     <= err_d;
    end
  end

  assign bus.cmd_ready = rdy_q && (state_q == ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_RSP);
  assign bus.rsp_dat   = rsp_dat_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.wbm_cyc_o = cyc_q;
  assign bus.wbm_stb_o = cyc_q;
  assign bus.wbm_we_o  = we_q;
  assign bus.wbm_sel_o = sel_q;
  assign bus.wbm_adr_o = adr_q;
  assign bus.wbm_dat_o = dat_q;
  assign busy          = (state_q != ST_IDLE);
  assign xfer_cnt      = xfer_q;
  assign err_cnt       = err_q;

endmodule

// File: doc/wb_initiator.md
WB_INITIATOR -- requirements
Module: wb_initiator

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the ack-wait cycles before abort; legal range 1..65535.
REQ-002 wb_clk_i  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 wb_rst_i  in  1  SHALL be the reset: asynchronous assert, active-low (0 = reset), synchronous deassert at the system level.
REQ-004 cmd_valid in 1, cmd_ready out 1, cmd_we in 1, cmd_sel in 4, cmd_adr in 32, cmd_dat in 32 SHALL form the command channel (valid/ready).
REQ-005 rsp_valid out 1, rsp_ready in 1, rsp_dat out 32, rsp_err out 1 SHALL form the response channel (valid/ready).
REQ-006 wbm_cyc_o out 1, wbm_stb_o out 1, wbm_we_o out 1, wbm_sel_o out 4, wbm_adr_o out 32, wbm_dat_o out 32 SHALL be Wishbone classic master outputs.
REQ-007 wbm_ack_i in 1, wbm_dat_i in 32 SHALL be Wishbone slave responses.
REQ-008 busy out 1 SHALL be high whenever state is not IDLE.
REQ-009 xfer_cnt out 16 SHALL count acked transfers; err_cnt out 8 SHALL count timeouts.

Function
REQ-010 States SHALL be IDLE, REQ, RSP.
REQ-011 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a rising edge with cmd_valid & cmd_ready.
REQ-012 On acceptance, command fields SHALL be registered onto wbm_we_o/sel_o/adr_o/dat_o and state SHALL move to REQ; wbm_cyc_o and wbm_stb_o SHALL be 1 from the following cycle.
REQ-013 In REQ, wbm_* outputs SHALL remain stable until the cycle ending the transfer.
REQ-014 In REQ, a wait counter (cleared on entry) SHALL increment each cycle wbm_ack_i = 0.
REQ-015 wbm_ack_i = 1 in REQ: on that edge, cyc/stb SHALL drop to 0, rsp_dat SHALL load wbm_dat_i for reads and 0 for writes, rsp_err SHALL load 0, xfer_cnt SHALL increment (wrap 0xFFFF->0), state SHALL go RSP.
REQ-016 Wait counter reaching TIMEOUT with no ack: cyc/stb SHALL drop, rsp_dat = 0, rsp_err = 1, err_cnt SHALL increment saturating at 0xFF, state SHALL go RSP.
REQ-017 Ack in the same cycle the counter reaches TIMEOUT SHALL be treated as ack (REQ-015).
REQ-018 wbm_ack_i outside REQ SHALL be ignored.
REQ-019 RSP: rsp_valid SHALL be 1 with rsp_dat/rsp_err stable until rsp_valid & rsp_ready, then state SHALL go IDLE.
REQ-020 With rsp_ready held 1 and ack on first stb cycle, command-to-command throughput SHALL be one transfer per 3 cycles.
REQ-021 Latency: cmd accepted at edge N -> stb high after N; ack sampled at edge M -> rsp_valid high after M.
REQ-022 cmd_valid in REQ/RSP SHALL not be consumed; command inputs are don't-care outside acceptance.
REQ-023 wbm_sel_o/adr_o/dat_o SHALL be driven as in REQ-012 regardless of cmd_we; only wbm_we_o differs.

Reset
REQ-024 wb_rst_i = 0 SHALL immediately force state IDLE, wbm_cyc_o = wbm_stb_o = wbm_we_o = 0, wbm_sel_o/adr_o/dat_o = 0, rsp_valid = 0, rsp_dat = 0, rsp_err = 0, busy = 0, xfer_cnt = 0, err_cnt = 0, wait counter = 0.
REQ-025 cmd_ready SHALL be 0 while wb_rst_i = 0 and 1 from the first edge after release.
REQ-026 Reset during REQ or RSP SHALL abort the transfer with no response issued and no counter update.

Structure
REQ-027 Package toysram_wb_pkg SHALL hold the state enum and constants WB_AW = 32, WB_DW = 32, WB_SELW = 4.
REQ-028 The wait counter with TIMEOUT compare SHALL be sub-module wb_init_timer (inputs clear, enable; output expired).

Verification
REQ-029 Write adr 0x0000_0010, dat 0xDEADBEEF, sel 0xF, ack after 2 wait cycles -> bus fields held 3 cycles, rsp_valid with rsp_dat 0, rsp_err 0, xfer_cnt 1.
REQ-030 Read adr 0x0000_0020, slave returns 0x1234_5678 with immediate ack, rsp_ready = 1 -> rsp_dat 0x1234_5678, next cmd_ready 3 cycles after first acceptance.
REQ-031 TIMEOUT = 4, slave never acks -> cyc/stb high exactly 4 cycles, rsp_err 1, rsp_dat 0, err_cnt 1.
REQ-032 TIMEOUT = 4, ack on 4th wait cycle -> rsp_err 0, xfer_cnt increments, err_cnt unchanged.
REQ-033 rsp_ready held 0 for 10 cycles, cmd_valid held 1, spurious wbm_ack_i pulses -> rsp stable, no new cyc, counters unchanged.
REQ-034 Assert wb_rst_i = 0 mid-REQ -> cyc/stb 0 same cycle, no rsp_valid, xfer_cnt/err_cnt 0 after release.
